// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: word handshake and serial output bundle for serial_pattern_tx.
interface serial_pattern_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              tx_bit;
   logic              tx_active;
   logic              frame_done;
   modport master (output in_data, in_valid, input in_ready, tx_bit, tx_active, frame_done);
   modport slave  (input in_data, in_valid, output in_ready, tx_bit, tx_active, frame_done);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends sync pattern then payload MSB first, one bit per clock.
// Optional even-parity bit after the payload when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx #(
   parameter int         DATA_W     = 8,
   parameter int         SYNC_LEN   = 3,
   parameter logic [7:0] SYNC_PAT   = 8'b0000_0101,
   parameter int         GAP_CYCLES = 1
) (
   input logic               clk,
   input logic               rst,
   serial_pattern_tx_if.slave bus
);
   localparam int MAX_SD = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
   localparam int MAXC   = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
   localparam int CW     = ($clog2(MAXC + 1) < 3) ? 3 : $clog2(MAXC + 1);

   // Sync pattern reordered so the bit sent in sync cycle k sits at index k.
   function automatic logic [7:0] rev_pat();
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < SYNC_LEN; k++) r[3'(k)] = SYNC_PAT[3'(SYNC_LEN - 1 - k)];
      return r;
   endfunction
   localparam logic [7:0] PAT_R = rev_pat();

`ifdef SERIAL_PATTERN_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP, PARITY} state_t;
`else
   typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif
   localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              in_ready_q, in_ready_d;
   logic              tx_bit_q, tx_bit_d;
   logic              tx_active_q, tx_active_d;
   logic              frame_done_q, frame_done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sh_d         = sh_q;
      frame_done_d = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: if (bus.in_valid && in_ready_q) begin
            state_d = SYNC;
            cnt_d   = '0;
            sh_d    = bus.in_data;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_d   = ^bus.in_data;
`endif
         end
         SYNC: begin
            state_d = (cnt_q == CW'(SYNC_LEN - 1)) ? DATA : SYNC;
            cnt_d   = (cnt_q == CW'(SYNC_LEN - 1)) ? '0 : cnt_q + CW'(1);
         end
         DATA: if (cnt_q == CW'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d      = POST;
            frame_done_d = 1'b1;
`endif
         end else begin
            cnt_d = cnt_q + CW'(1);
            sh_d  = sh_q << 1;
         end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         PARITY: begin
            state_d      = POST;
            frame_done_d = 1'b1;
         end
`endif
         GAP: begin
            state_d = (cnt_q == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            cnt_d   = (cnt_q == CW'(GAP_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
         end
      endcase
      // Outputs are registered copies of what the next state presents.
      in_ready_d = (state_d == IDLE);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      tx_active_d = (state_d == SYNC) || (state_d == DATA) || (state_d == PARITY);
      tx_bit_d    = (state_d == SYNC) ? PAT_R[cnt_d[2:0]] :
                    (state_d == DATA) ? sh_d[DATA_W-1] : (state_d == PARITY) && par_d;
`else
      tx_active_d = (state_d == SYNC) || (state_d == DATA);
      tx_bit_d    = (state_d == SYNC) ? PAT_R[cnt_d[2:0]] : (state_d == DATA) && sh_d[DATA_W-1];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sh_q         <= '0;
         in_ready_q   <= 1'b1;
         tx_bit_q     <= 1'b0;
         tx_active_q  <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_q         <= sh_d;
         in_ready_q   <= in_ready_d;
         tx_bit_q     <= tx_bit_d;
         tx_active_q  <= tx_active_d;
         frame_done_q <= frame_done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.tx_bit     = tx_bit_q;
   assign bus.tx_active  = tx_active_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial frame transmitter; the transmit-side counterpart of the team's serial pattern-detector FSMs.
- Accepts a parallel word over a valid/ready handshake.
- Emits a fixed sync pattern (default "101") followed by the word, MSB first, one bit per clock on tx_bit.
- Feeds serial detectors/receivers in the same design and provides stimulus for pattern-matching blocks.

Parameters:
DATA_W, 8, payload width in bits (>=1)
SYNC_LEN, 3, sync pattern length in bits (1..8)
SYNC_PAT, 8'b0000_0101, sync pattern; low SYNC_LEN bits used, sent MSB (bit SYNC_LEN-1) first
GAP_CYCLES, 1, forced idle cycles after each frame (0..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  DATA_W  payload word, sampled on handshake
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word (registered)
tx_bit  output  1  serial output bit (registered)
tx_active  output  1  high while tx_bit carries a sync/data/parity bit
frame_done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset values: state IDLE, in_ready=1, tx_bit=0, tx_active=0, frame_done=0, shift register and counters 0.
- rst has priority over all other events.
- States:
  - IDLE: in_ready=1, tx_bit=0, tx_active=0. Handshake = in_valid&in_ready at a rising edge. On handshake: capture in_data into the shift register, clear the bit counter, go to SYNC.
  - SYNC: SYNC_LEN cycles. tx_bit = SYNC_PAT[SYNC_LEN-1-k] in cycle k. tx_active=1, in_ready=0. Then DATA.
  - DATA: DATA_W cycles, shift register MSB first, tx_active=1. Then PARITY if the macro is defined, else GAP, or IDLE when GAP_CYCLES=0.
  - GAP: GAP_CYCLES cycles, tx_bit=0, tx_active=0, in_ready=0. Then IDLE.
- Latency, handshake at edge E0 (GAP_CYCLES=1, DATA_W=8, SYNC_LEN=3):
  - Cycles 1..3: sync bits.
  - Cycles 4..11: data bits.
  - Cycle 12: frame_done=1, tx_active=0, tx_bit=0 (first GAP cycle).
  - Cycle 13: in_ready=1.
  - Minimum frame period: SYNC_LEN+DATA_W+GAP_CYCLES+1 cycles.
- GAP_CYCLES=0: frame_done and in_ready=1 both occur in the first cycle after the last bit. A handshake at the end of that cycle starts the next sync bit immediately. Back-to-back period is SYNC_LEN+DATA_W+1.
- frame_done is exactly one cycle wide, once per completed frame.
- in_valid while in_ready=0 is ignored; no capture. Upstream holds in_data/in_valid until the handshake.
- in_data changes during SYNC/DATA do not affect the frame in flight.
- Reset mid-frame:
  - The frame is abandoned at the next edge; all outputs return to reset values.
  - No frame_done for the abandoned frame.
  - The word is not retransmitted.
- Counters are sized to hold max(SYNC_LEN, DATA_W, GAP_CYCLES). No wrap occurs within a state.
- Unused/illegal state encodings recover to IDLE with reset output values.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN
- Defined:
  - PARITY state of one cycle after DATA, tx_active=1.
  - tx_bit = even parity (XOR) of the captured word.
  - Frame length +1; frame_done and all subsequent timing shift one cycle later.
- Undefined: no PARITY state or logic; DATA goes directly to GAP/IDLE.

Test Plan:
1. Reset, then in_data=8'hA5 with in_valid=1 for one cycle (defaults) -> tx_bit cycles 1..11 = 1,0,1, 1,0,1,0,0,1,0,1. tx_active=1 in cycles 1..11. frame_done=1 only in cycle 12. in_ready=1 again in cycle 13.
2. Two words 8'hFF then 8'h00 with in_valid held continuously -> second handshake in cycle 13. Second frame = 1,0,1 then eight 0s in cycles 14..24. Exactly two frame_done pulses.
3. in_valid=1 with in_data toggling between 8'h3C and 8'hC3 every cycle during a frame -> transmitted payload equals the value present at the handshake edge only. No extra handshakes while in_ready=0.
4. rst asserted in cycle 6 of a frame -> next cycle tx_bit=0, tx_active=0, in_ready=1, no frame_done. A new word 8'h81 afterwards is sent correctly.
5. GAP_CYCLES=0, DATA_W=4, in_valid held with 4'h9 -> continuous stream 1,0,1,1,0,0,1 with one idle cycle between frames. Period 8 cycles.
6. SERIAL_PATTERN_TX_PARITY_EN defined, in_data=8'h07 -> parity bit 1 in cycle 12, frame_done in cycle 13. With 8'h03 -> parity bit 0.
